// File: rtl/muldiv_ex_pkg.sv
// Shared opcodes, FSM encoding and opcode classifiers for the RV32M execute unit.
// Opcode values match the EX-stage ALU control decoder.
package muldiv_ex_pkg;

    localparam int MD_XLEN    = 32;
    localparam int MD_ALUOP_W = 5;

    typedef enum logic [MD_ALUOP_W-1:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_SLL    = 5'd2,
        ALU_SLT    = 5'd3,
        ALU_SLTU   = 5'd4,
        ALU_XOR    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_OR     = 5'd8,
        ALU_AND    = 5'd9,
        ALU_LUI    = 5'd10,
        ALU_MUL    = 5'd16,
        ALU_MULH   = 5'd17,
        ALU_MULHSU = 5'd18,
        ALU_MULHU  = 5'd19,
        ALU_DIV    = 5'd20,
        ALU_DIVU   = 5'd21,
        ALU_REM    = 5'd22,
        ALU_REMU   = 5'd23
    } aluop_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    function automatic logic is_mul_op(input logic [MD_ALUOP_W-1:0] op);
        return (op == ALU_MUL) || (op == ALU_MULH) || (op == ALU_MULHSU) || (op == ALU_MULHU);
    endfunction

    function automatic logic is_div_op(input logic [MD_ALUOP_W-1:0] op);
        return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
    endfunction

    function automatic logic is_signed_div(input logic [MD_ALUOP_W-1:0] op);
        return (op == ALU_DIV) || (op == ALU_REM);
    endfunction

    function automatic logic returns_quot(input logic [MD_ALUOP_W-1:0] op);
        return (op == ALU_DIV) || (op == ALU_DIVU);
    endfunction

    function automatic logic mul_a_signed(input logic [MD_ALUOP_W-1:0] op);
        return (op == ALU_MUL) || (op == ALU_MULH) || (op == ALU_MULHSU);
    endfunction

    function automatic logic mul_b_signed(input logic [MD_ALUOP_W-1:0] op);
        return (op == ALU_MUL) || (op == ALU_MULH);
    endfunction

endpackage

// File: rtl/muldiv_ex_div_iter.sv
// Restoring divider on unsigned magnitudes: one quotient bit per step, XLEN steps.
// fin_o flags the step that produces the last quotient bit.
module div_iter
    import muldiv_ex_pkg::*;
#(
    parameter int XLEN = MD_XLEN
) (
    input  logic            clock_i,
    input  logic            reset_i,
    input  logic            load_i,
    input  logic            step_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] quotient_o,
    output logic [XLEN-1:0] remainder_o,
    output logic            fin_o
);

    localparam int CNT_W = $clog2(XLEN);

    logic [XLEN-1:0]  rem_q, rem_d;
    logic [XLEN-1:0]  quo_q, quo_d;
    logic [XLEN-1:0]  dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN:0]    rem_sh;
    logic [XLEN:0]    trial;

    // quo_q starts as the dividend and shifts quotient bits in from the right
    always_comb begin
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        rem_sh = {rem_q, quo_q[XLEN-1]};
        trial  = rem_sh - {1'b0, dvs_q};
        if (load_i) begin
            rem_d = '0;
            quo_d = dividend_i;
            dvs_d = divisor_i;
            cnt_d = '0;
        end else if (step_i) begin
            if (!trial[XLEN]) begin
                rem_d = trial[XLEN-1:0];
                quo_d = {quo_q[XLEN-2:0], 1'b1};
            end else begin
                rem_d = rem_sh[XLEN-1:0];
                quo_d = {quo_q[XLEN-2:0], 1'b0};
            end
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
            cnt_q <= cnt_d;
        end
    end

    assign fin_o       = step_i && (cnt_q == CNT_W'(XLEN - 1));
    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;

endmodule

// File: rtl/muldiv_ex.sv
// RV32M execute unit: one-cycle multiply, 32-step divide with a sign-fix cycle,
// and immediate answers for divide-by-zero and signed overflow.
module muldiv_ex
    import muldiv_ex_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ALUOP_W = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [ALUOP_W-1:0] ALUOp,
    input  logic [XLEN-1:0]    inA,
    input  logic [XLEN-1:0]    inB,
    input  logic               kill,
    output logic               busy,
    output logic               done,
    output logic [XLEN-1:0]    result
);

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    state_e               state_q, state_d;
    logic [ALUOP_W-1:0]   op_q, op_d;
    logic [XLEN-1:0]      a_q, a_d;
    logic [XLEN-1:0]      b_q, b_d;
    logic [XLEN-1:0]      result_q, result_d;

    logic                 is_mul, is_div, is_m;
    logic                 div_zero, div_ovf, special, accept;
    logic [XLEN-1:0]      special_res;
    logic [XLEN-1:0]      mag_a, mag_b;

    logic signed [XLEN:0]     mul_a, mul_b;
    logic signed [2*XLEN+1:0] mul_ea, mul_eb, mul_prod;
    logic [XLEN-1:0]          mul_res;
    logic                     mul_unused;

    logic                 div_load, div_step, div_fin;
    logic [XLEN-1:0]      quo, rem, fix_res;
    logic                 neg_quo, neg_rem;

    assign is_mul = is_mul_op(ALUOp);
    assign is_div = is_div_op(ALUOp);
    assign is_m   = is_mul || is_div;
    assign accept = (state_q == ST_IDLE) && start && !kill && is_m;

    // Cases answered without iterating: divide by zero and INT_MIN / -1
    assign div_zero = (inB == '0);
    assign div_ovf  = is_signed_div(ALUOp) && (inA == INT_MIN) && (inB == '1);
    assign special  = is_div && (div_zero || div_ovf);

    always_comb begin
        special_res = '0;
        if (div_zero) begin
            special_res = returns_quot(ALUOp) ? '1 : inA;
        end else if (div_ovf) begin
            special_res = returns_quot(ALUOp) ? INT_MIN : '0;
        end
    end

    assign mag_a = (is_signed_div(ALUOp) && inA[XLEN-1]) ? ('0 - inA) : inA;
    assign mag_b = (is_signed_div(ALUOp) && inB[XLEN-1]) ? ('0 - inB) : inB;

    // 33-bit extended operands widened to a 66-bit signed product
    assign mul_a      = {mul_a_signed(op_q) & a_q[XLEN-1], a_q};
    assign mul_b      = {mul_b_signed(op_q) & b_q[XLEN-1], b_q};
    assign mul_ea     = {{(XLEN+1){mul_a[XLEN]}}, mul_a};
    assign mul_eb     = {{(XLEN+1){mul_b[XLEN]}}, mul_b};
    assign mul_prod   = mul_ea * mul_eb;
    assign mul_res    = (op_q == ALU_MUL) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];
    assign mul_unused = ^mul_prod[2*XLEN+1:2*XLEN];

    assign div_load = accept && is_div && !special;
    assign div_step = (state_q == ST_DIV);

    div_iter #(.XLEN(XLEN)) u_div_iter (
        .clock_i     (clock),
        .reset_i     (reset),
        .load_i      (div_load),
        .step_i      (div_step),
        .dividend_i  (mag_a),
        .divisor_i   (mag_b),
        .quotient_o  (quo),
        .remainder_o (rem),
        .fin_o       (div_fin)
    );

    assign neg_quo = is_signed_div(op_q) && (a_q[XLEN-1] ^ b_q[XLEN-1]);
    assign neg_rem = is_signed_div(op_q) && a_q[XLEN-1];
    assign fix_res = returns_quot(op_q) ? (neg_quo ? ('0 - quo) : quo)
                                        : (neg_rem ? ('0 - rem) : rem);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_mul)       state_d = ST_MUL;
                    else if (special) state_d = ST_DONE;
                    else              state_d = ST_DIV;
                end
            end
            ST_MUL:  state_d = kill ? ST_IDLE : ST_DONE;
            ST_DIV:  state_d = kill ? ST_IDLE : (div_fin ? ST_FIX : ST_DIV);
            ST_FIX:  state_d = kill ? ST_IDLE : ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == ST_MUL) || (state_q == ST_DIV) || (state_q == ST_FIX);
        done = (state_q == ST_DONE);
    end

    // result only moves on the edge that enters DONE
    always_comb begin
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        if (accept) begin
            op_d = ALUOp;
            a_d  = inA;
            b_d  = inB;
        end
        case (state_q)
            ST_IDLE: if (accept && special) result_d = special_res;
            ST_MUL:  if (!kill) result_d = mul_res;
            ST_FIX:  if (!kill) result_d = fix_res;
            default: result_d = result_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else begin
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;

endmodule
